// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master bus interconnect:
// FSM encoding, default slave address map and the data/address slice width.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } bus_state_e;

  localparam int unsigned BUS_BYTE_AMNT = 8;
  localparam int unsigned BUS_DW        = 8 * BUS_BYTE_AMNT;

  localparam logic [63:0] ROM_BASE   = 64'h0;
  localparam logic [63:0] ROM_MASK   = ~64'hFFFFFF;
  localparam logic [63:0] RAM_BASE   = 64'h04000000;
  localparam logic [63:0] RAM_MASK   = ~64'h3FFFFFF;
  localparam logic [63:0] UART_BASE  = 64'h10013000;
  localparam logic [63:0] UART_MASK  = ~64'hFFF;
  localparam logic [63:0] CLINT_BASE = 64'hFFFFFFC0;
  localparam logic [63:0] CLINT_MASK = ~64'h3F;

  function automatic int unsigned slice_w(input int unsigned byte_amnt);
    return 8 * byte_amnt;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Base/mask address decoder: reports whether any slave matches and, when several
// do, selects the lowest index as both a one-hot grant and a binary index.
module bus_addr_decoder #(
  parameter int unsigned AW     = 64,
  parameter int unsigned SLAVES = 4,
  parameter int unsigned IDX_W  = 2,
  parameter logic [SLAVES*64-1:0] BASE_ADDRS = '0,
  parameter logic [SLAVES*64-1:0] ADDR_MASKS = '0
) (
  input  logic [AW-1:0]     adr_i,
  output logic [SLAVES-1:0] match_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              hit_o
);

  logic [SLAVES-1:0] raw_match;

  always_comb begin
    raw_match = '0;
    match_o   = '0;
    idx_o     = '0;
    hit_o     = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      raw_match[i] = ((adr_i & ADDR_MASKS[i*64 +: AW]) == BASE_ADDRS[i*64 +: AW]);
    end
    // Walk from the top down so the lowest matching index is the last writer.
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (raw_match[i]) begin
        match_o    = '0;
        match_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
        hit_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_interconnect.sv
// Registered single-master / N-slave interconnect, one transaction in flight.
// Define BUS_TIMEOUT_EN to abort a slave that never acknowledges after TIMEOUT_CYCLES.
module bus_interconnect
  import bus_pkg::*;
#(
  parameter int unsigned BYTE_AMNT = BUS_BYTE_AMNT,
  parameter int unsigned SLAVES    = 4,
  parameter logic [SLAVES*64-1:0] BASE_ADDRS = {CLINT_BASE, UART_BASE, RAM_BASE, ROM_BASE},
  parameter logic [SLAVES*64-1:0] ADDR_MASKS = {CLINT_MASK, UART_MASK, RAM_MASK, ROM_MASK},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                            CLK_I,
  input  logic                            RST_I,
  input  logic                            cpu_STB_I,
  input  logic                            cpu_WE_I,
  input  logic [BYTE_AMNT-1:0]            cpu_SEL_I,
  input  logic [8*BYTE_AMNT-1:0]          cpu_ADR_I,
  input  logic [8*BYTE_AMNT-1:0]          cpu_DAT_I,
  output logic [8*BYTE_AMNT-1:0]          cpu_DAT_O,
  output logic                            cpu_ACK_O,
  output logic                            cpu_ERR_O,
  output logic [SLAVES-1:0]               slv_STB_O,
  output logic [SLAVES-1:0]               slv_WE_O,
  output logic [SLAVES*BYTE_AMNT-1:0]     slv_SEL_O,
  output logic [SLAVES*8*BYTE_AMNT-1:0]   slv_ADR_O,
  output logic [SLAVES*8*BYTE_AMNT-1:0]   slv_DAT_O,
  input  logic [SLAVES*8*BYTE_AMNT-1:0]   slv_DAT_I,
  input  logic [SLAVES-1:0]               slv_ACK_I
);

  localparam int unsigned DW    = slice_w(BYTE_AMNT);
  localparam int unsigned IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  bus_state_e state_q, state_d;
  logic                 we_q, we_d;
  logic [BYTE_AMNT-1:0] sel_q, sel_d;
  logic [DW-1:0]        adr_q, adr_d;
  logic [DW-1:0]        dat_q, dat_d;
  logic [DW-1:0]        rdat_q, rdat_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SLAVES-1:0]    oh_q, oh_d;

  logic [SLAVES-1:0]    dec_oh;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_hit;
  logic                 ack_sel;
  logic [DW-1:0]        rdat_sel;
  logic                 timeout;

  bus_addr_decoder #(
    .AW         (DW),
    .SLAVES     (SLAVES),
    .IDX_W      (IDX_W),
    .BASE_ADDRS (BASE_ADDRS),
    .ADDR_MASKS (ADDR_MASKS)
  ) u_dec (
    .adr_i   (cpu_ADR_I),
    .match_o (dec_oh),
    .idx_o   (dec_idx),
    .hit_o   (dec_hit)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count is zero in the first BUSY cycle, so the terminal value leaves the
  // strobe up for exactly TIMEOUT_CYCLES cycles.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == S_BUSY) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    ack_sel = slv_ACK_I[idx_q];
    rdat_sel = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (oh_q[i]) rdat_sel = slv_DAT_I[i*DW +: DW];
    end
    case (state_q)
      S_IDLE: begin
        if (cpu_STB_I) begin
          we_d    = cpu_WE_I;
          sel_d   = cpu_SEL_I;
          adr_d   = cpu_ADR_I;
          dat_d   = cpu_DAT_I;
          idx_d   = dec_idx;
          oh_d    = dec_oh;
          rdat_d  = '0;
          state_d = dec_hit ? S_BUSY : S_ERROR;
        end
      end
      S_BUSY: begin
        // An ACK coinciding with the terminal count still completes normally.
        if (ack_sel) begin
          rdat_d  = we_q ? '0 : rdat_sel;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    slv_STB_O = '0;
    slv_WE_O  = '0;
    slv_SEL_O = '0;
    slv_ADR_O = '0;
    slv_DAT_O = '0;
    cpu_ACK_O = (state_q == S_DONE);
    cpu_ERR_O = (state_q == S_ERROR);
    cpu_DAT_O = (state_q == S_DONE) ? rdat_q : '0;
    if (state_q == S_BUSY) begin
      for (int i = 0; i < SLAVES; i++) begin
        if (oh_q[i]) begin
          slv_STB_O[i]                         = 1'b1;
          slv_WE_O[i]                          = we_q;
          slv_SEL_O[i*BYTE_AMNT +: BYTE_AMNT]  = sel_q;
          slv_ADR_O[i*DW +: DW]                = adr_q & ~ADDR_MASKS[i*64 +: DW];
          slv_DAT_O[i*DW +: DW]                = dat_q;
        end
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: directed scenarios plus randomized transactions
// checked against an address-map model and a cycle-accurate handshake model.
module tb_bus_interconnect;

  localparam int NS = 4;

  logic         clk;
  logic         rst;
  logic         cpu_STB_I;
  logic         cpu_WE_I;
  logic [7:0]   cpu_SEL_I;
  logic [63:0]  cpu_ADR_I;
  logic [63:0]  cpu_DAT_I;
  logic [63:0]  cpu_DAT_O;
  logic         cpu_ACK_O;
  logic         cpu_ERR_O;
  logic [3:0]   slv_STB_O;
  logic [3:0]   slv_WE_O;
  logic [31:0]  slv_SEL_O;
  logic [255:0] slv_ADR_O;
  logic [255:0] slv_DAT_O;
  logic [255:0] slv_DAT_I;
  logic [3:0]   slv_ACK_I;

  bus_interconnect dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .cpu_STB_I (cpu_STB_I),
    .cpu_WE_I  (cpu_WE_I),
    .cpu_SEL_I (cpu_SEL_I),
    .cpu_ADR_I (cpu_ADR_I),
    .cpu_DAT_I (cpu_DAT_I),
    .cpu_DAT_O (cpu_DAT_O),
    .cpu_ACK_O (cpu_ACK_O),
    .cpu_ERR_O (cpu_ERR_O),
    .slv_STB_O (slv_STB_O),
    .slv_WE_O  (slv_WE_O),
    .slv_SEL_O (slv_SEL_O),
    .slv_ADR_O (slv_ADR_O),
    .slv_DAT_O (slv_DAT_O),
    .slv_DAT_I (slv_DAT_I),
    .slv_ACK_I (slv_ACK_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] m_base [NS] = '{64'h0, 64'h04000000, 64'h10013000, 64'hFFFFFFC0};
  logic [63:0] m_mask [NS] = '{~64'hFFFFFF, ~64'h3FFFFFF, ~64'hFFF, ~64'h3F};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_decode(input logic [63:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_stb"}, slv_STB_O, 0);
    check({tag, "_we"},  slv_WE_O, 0);
    check({tag, "_sel"}, slv_SEL_O, 0);
    check({tag, "_adr"}, slv_ADR_O, 0);
    check({tag, "_dat"}, slv_DAT_O, 0);
    check({tag, "_ack"}, cpu_ACK_O, 0);
    check({tag, "_err"}, cpu_ERR_O, 0);
    check({tag, "_cdat"}, cpu_DAT_O, 0);
  endtask

  task automatic check_busy(input int idx, input logic we, input logic [7:0] sel,
                            input logic [63:0] adr, input logic [63:0] dat);
    logic [63:0] off;
    off = adr & ~m_mask[idx];
    check("busy_stb", slv_STB_O, 256'(1) << idx);
    check("busy_we",  slv_WE_O, we ? (256'(1) << idx) : 256'(0));
    check("busy_sel", slv_SEL_O, 256'(sel) << (8 * idx));
    check("busy_adr", slv_ADR_O, 256'(off) << (64 * idx));
    check("busy_dat", slv_DAT_O, 256'(dat) << (64 * idx));
    check("busy_resp", {cpu_ACK_O, cpu_ERR_O}, 0);
  endtask

  // Called just after a falling edge; returns just after the falling edge of
  // the idle cycle that follows the response.
  task automatic do_txn(input logic [63:0] adr, input logic we, input logic [7:0] sel,
                        input logic [63:0] dat, input int delay, input logic [63:0] rdat,
                        input bit stray, input bit hold, input bit scramble);
    int idx;
    idx = ref_decode(adr);
    cpu_STB_I = 1'b1;
    cpu_WE_I  = we;
    cpu_SEL_I = sel;
    cpu_ADR_I = adr;
    cpu_DAT_I = dat;
    slv_ACK_I = '0;
    @(negedge clk);
    if (idx < 0) begin
      check("err_pulse", cpu_ERR_O, 1);
      check("err_ack", cpu_ACK_O, 0);
      check("err_cdat", cpu_DAT_O, 0);
      check("err_stb", slv_STB_O, 0);
      if (!hold) cpu_STB_I = 1'b0;
      @(negedge clk);
      check_idle("after_err");
      return;
    end
    for (int c = 1; c <= delay; c++) begin
      check_busy(idx, we, sel, adr, dat);
      slv_DAT_I = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      slv_ACK_I = '0;
      if (stray) slv_ACK_I[(idx + 1 + $urandom_range(0, 2)) % NS] = 1'b1;
      if (scramble) begin
        cpu_ADR_I = {$urandom, $urandom};
        cpu_WE_I  = 1'($urandom);
        cpu_SEL_I = 8'($urandom);
        cpu_DAT_I = {$urandom, $urandom};
      end
      if (c == delay) begin
        slv_ACK_I[idx] = 1'b1;
        slv_DAT_I[64*idx +: 64] = rdat;
      end
      @(negedge clk);
    end
    slv_ACK_I = '0;
    check("ack_pulse", cpu_ACK_O, 1);
    check("ack_err", cpu_ERR_O, 0);
    check("ack_cdat", cpu_DAT_O, we ? 64'h0 : rdat);
    check("ack_stb", slv_STB_O, 0);
    if (!hold) cpu_STB_I = 1'b0;
    @(negedge clk);
    check_idle("after_ack");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst = 1'b1;
    cpu_STB_I = 1'b0; cpu_WE_I = 1'b0; cpu_SEL_I = '0;
    cpu_ADR_I = '0;   cpu_DAT_I = '0;
    slv_DAT_I = '0;   slv_ACK_I = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // RAM read, slave answers two cycles after its strobe rises
    do_txn(64'h04000010, 1'b0, 8'hFF, 64'h0, 3, 64'hDEADBEEF_CAFEF00D, 0, 0, 0);
    // UART write
    do_txn(64'h10013004, 1'b1, 8'h0F, 64'h41, 2, 64'h1234_5678_9ABC_DEF0, 0, 0, 0);
    // Unmapped
    do_txn(64'h20000000, 1'b0, 8'hFF, 64'h0, 1, 64'h0, 0, 0, 0);
    // Back-to-back ROM reads with STB held, stray ACKs on other slaves
    do_txn(64'h0, 1'b0, 8'hFF, 64'h0, 1, 64'h1111_2222_3333_4444, 1, 1, 0);
    do_txn(64'h8, 1'b0, 8'hFF, 64'h0, 3, 64'h5555_6666_7777_8888, 1, 0, 0);

    // CLINT slave that never acknowledges
    cpu_STB_I = 1'b1; cpu_WE_I = 1'b0; cpu_SEL_I = 8'hFF;
    cpu_ADR_I = 64'hFFFFFFC0; cpu_DAT_I = '0; slv_ACK_I = '0;
    @(negedge clk);
    hi = 0;
`ifdef BUS_TIMEOUT_EN
    while (slv_STB_O[3] && hi < 400) begin
      hi++;
      @(negedge clk);
    end
    check("timeout_len", 256'(hi), 256'(255));
    check("timeout_err", cpu_ERR_O, 1);
    check("timeout_stb", slv_STB_O, 0);
    cpu_STB_I = 1'b0;
    @(negedge clk);
    check_idle("after_timeout");
`else
    repeat (999) begin
      if (slv_STB_O == 4'b1000) hi++;
      @(negedge clk);
    end
    if (slv_STB_O == 4'b1000) hi++;
    check("no_timeout_cycles", 256'(hi), 256'(1000));
    check("no_timeout_err", cpu_ERR_O, 0);
    rst = 1'b1;
    cpu_STB_I = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_stuck");
`endif

    // Reset in the middle of a RAM transaction, then a late ACK
    cpu_STB_I = 1'b1; cpu_WE_I = 1'b0; cpu_ADR_I = 64'h04000100;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_stb", slv_STB_O, 4'b0010);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    cpu_STB_I = 1'b0;
    rst = 1'b0;
    slv_ACK_I[1] = 1'b1;
    slv_DAT_I[127:64] = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check_idle("late_ack1");
    @(negedge clk);
    check_idle("late_ack2");
    slv_ACK_I = '0;

    for (int t = 0; t < 200; t++) begin
      logic [63:0] a;
      case ($urandom_range(0, 4))
        0: a = {$urandom, $urandom} & 64'hFFFFFF;
        1: a = 64'h04000000 | ({$urandom, $urandom} & 64'h3FFFFFF);
        2: a = 64'h10013000 | ({$urandom, $urandom} & 64'hFFF);
        3: a = 64'hFFFFFFC0 | ({$urandom, $urandom} & 64'h3F);
        default: a = {$urandom, $urandom};
      endcase
      do_txn(a, 1'($urandom), 8'($urandom), {$urandom, $urandom}, $urandom_range(1, 4),
             {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    cpu_STB_I = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_interconnect.md
Name: bus_interconnect

Overview:
- Parametrised single-master, N-slave bus interconnect. It is the registered, handshaked successor of the combinational memory decoder.
- Sits between the core's data-memory port and the memory/peripheral slaves: ROM/instruction cache, RAM, UART and CSR-mapped timer registers.
- Decodes the address against a per-slave base/mask table and forwards one transaction at a time.
- Returns the response with ACK or ERR. Unmapped addresses return ERR instead of silently hanging.

Parameters:
- BYTE_AMNT, 8, bytes per data/address word; data width is 8*BYTE_AMNT.
- SLAVES, 4, number of slave channels.
- BASE_ADDRS, {64'hFFFFFFC0, 64'h10013000, 64'h04000000, 64'h0}, packed SLAVES x 64-bit base table; slave i occupies slice i.
- ADDR_MASKS, {~64'h3F, ~64'hFFF, ~64'h3FFFFFF, ~64'hFFFFFF}, packed SLAVES x 64-bit mask table. Slave i matches when (ADR & MASK_i) == BASE_i.
- TIMEOUT_CYCLES, 255, wait bound used only with BUS_TIMEOUT_EN.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous active-high reset
- cpu_STB_I  in  1  request strobe
- cpu_WE_I  in  1  write enable
- cpu_SEL_I  in  BYTE_AMNT  byte selects
- cpu_ADR_I  in  8*BYTE_AMNT  address
- cpu_DAT_I  in  8*BYTE_AMNT  write data
- cpu_DAT_O  out  8*BYTE_AMNT  read data
- cpu_ACK_O  out  1  transaction done
- cpu_ERR_O  out  1  decode error / timeout
- slv_STB_O  out  SLAVES  per-slave strobe
- slv_WE_O  out  SLAVES  per-slave write enable
- slv_SEL_O  out  SLAVES*BYTE_AMNT  per-slave byte selects
- slv_ADR_O  out  SLAVES*8*BYTE_AMNT  per-slave offset address
- slv_DAT_O  out  SLAVES*8*BYTE_AMNT  per-slave write data
- slv_DAT_I  in  SLAVES*8*BYTE_AMNT  per-slave read data
- slv_ACK_I  in  SLAVES  per-slave acknowledge

Behaviour:
- Reset: one clock (CLK_I); reset is asynchronous and active-high (RST_I).
  - On RST_I, including mid-transaction, state goes to IDLE.
  - All outputs go to 0; latched request registers are cleared.
  - A slave ACK that arrives after reset is ignored.
- FSM states: IDLE, BUSY, DONE, ERROR.
- IDLE:
  - When cpu_STB_I=1, latch WE/SEL/ADR/DAT and decode.
  - If several slaves match, the lowest index wins.
  - A match goes to BUSY with index latched. No match goes to ERROR.
- BUSY:
  - Drive only slv_STB_O[idx]=1 and slv_WE_O[idx]=WE.
  - Drive slv_SEL_O, slv_DAT_O and slv_ADR_O = ADR & ~MASK_idx on slice idx; all other slices are 0.
  - When slv_ACK_I[idx]=1, capture slv_DAT_I slice idx (reads only; writes capture 0) and go to DONE.
  - ACKs on non-selected slaves are ignored.
- DONE: cpu_ACK_O=1 and cpu_DAT_O=captured data for exactly one cycle, then IDLE.
- ERROR: cpu_ERR_O=1 and cpu_DAT_O=0 for exactly one cycle, then IDLE.
- cpu_ACK_O and cpu_ERR_O are never high together. cpu_DAT_O is 0 outside DONE.
- Latency:
  - Request seen at edge 0; slave strobe is high from cycle 1.
  - A slave ACK in cycle k gives cpu_ACK_O in cycle k+1.
  - Minimum round trip is 3 cycles.
  - A decode error gives cpu_ERR_O in cycle 1.
- Master handshake:
  - The master holds inputs stable until ACK/ERR and may drop STB in the ACK cycle.
  - STB is sampled only in IDLE, so back-to-back requests have one idle cycle between them.
  - Input changes during BUSY have no effect.
- A slave ACK in the same cycle that BUSY is entered is impossible, because the strobe is registered.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With it defined:
  - An 8-bit-or-wider counter clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES without an ACK, the slave strobe drops and the FSM goes to ERROR.
  - An ACK in the same cycle as the terminal count wins, so the transaction goes to DONE.
- Without it: no counter exists, and BUSY waits indefinitely for ACK.

Decomposition:
- Shared package bus_pkg holds:
  - FSM state encoding (IDLE=0, BUSY=1, DONE=2, ERROR=3).
  - Default base/mask constants for ROM, RAM, UART and CLINT.
  - The slice-width constant 8*BYTE_AMNT.
- One sub-module: bus_addr_decoder.
  - Combinational base/mask compare producing a one-hot match vector, priority index and hit flag.
  - Parametrised by SLAVES, BASE_ADDRS and ADDR_MASKS.

Test Plan:
- Read from RAM:
  - Stimulus: ADR=0x0400_0010, WE=0; slave 1 ACKs 2 cycles after its STB with data 0xDEADBEEF_CAFEF00D.
  - Response: slv_ADR_O slice 1 = 0x10; cpu_ACK_O one cycle later with the same data; other slave strobes stay 0.
- Write to UART:
  - Stimulus: ADR=0x1001_3004, WE=1, SEL=0x0F, DAT=0x41.
  - Response: slave 2 sees offset 0x4, SEL 0x0F, DAT 0x41; cpu_ACK_O pulses once with cpu_DAT_O=0.
- Unmapped address:
  - Stimulus: ADR=0x2000_0000.
  - Response: cpu_ERR_O=1 in cycle 1 for one cycle; no slv_STB_O asserted.
- Timeout, with BUS_TIMEOUT_EN:
  - Stimulus: access to the CLINT at 0xFFFF_FFC0 whose slave never ACKs.
  - Response: slv_STB_O[3] drops after 255 cycles; cpu_ERR_O pulses.
  - Without the macro: still BUSY at cycle 1000.
- Reset mid-transaction:
  - Stimulus: assert RST_I during BUSY, then send a late slv_ACK_I.
  - Response: all outputs 0 immediately; the late ACK produces no cpu_ACK_O.
- Back-to-back and stray ACK:
  - Stimulus: two consecutive reads to ROM at 0x0 and 0x8 with STB held; a stray slv_ACK_I[1] during slave-0 BUSY.
  - Response: two distinct cpu_ACK_O pulses separated by an IDLE cycle; the stray ACK is ignored.
